// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone B4 signal bundle for wb_cmd_master.
// The master modport is the bridge's view; slave is the command source plus bus target.
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [29:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] txn_count;
  logic [29:0] wishbone_adr;
  logic [31:0] wishbone_dat_w;
  logic [31:0] wishbone_dat_r;
  logic [3:0]  wishbone_sel;
  logic        wishbone_cyc;
  logic        wishbone_stb;
  logic        wishbone_we;
  logic        wishbone_ack;
  logic        wishbone_err;
  logic [2:0]  wishbone_cti;
  logic [1:0]  wishbone_bte;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wishbone_dat_r, wishbone_ack, wishbone_err,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout, txn_count,
           wishbone_adr, wishbone_dat_w, wishbone_sel, wishbone_cyc, wishbone_stb,
           wishbone_we, wishbone_cti, wishbone_bte
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wishbone_dat_r, wishbone_ack, wishbone_err,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout, txn_count,
           wishbone_adr, wishbone_dat_w, wishbone_sel, wishbone_cyc, wishbone_stb,
           wishbone_we, wishbone_cti, wishbone_bte
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-word Wishbone B4 classic master: one command in, one bus cycle, one response out.
// Define WB_MASTER_TIMEOUT_EN to abort cycles that see no ack/err within TIMEOUT_CYCLES.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  wb_cmd_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] txn_count_q, txn_count_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_w_q, dat_w_d;
  logic [3:0]  sel_q, sel_d;
  logic        bus_done;
`ifdef WB_MASTER_TIMEOUT_EN
  // Counter value on the last stb cycle allowed before abort.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_w_d     = dat_w_q;
    sel_d       = sel_q;
    bus_done    = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          adr_d   = bus.cmd_adr;
          dat_w_d = bus.cmd_dat;
          sel_d   = bus.cmd_sel;
          we_d    = bus.cmd_we;
          cyc_d   = 1'b1;
          state_d = StBus;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      StBus: begin
        // err outranks a simultaneous ack and suppresses read data.
        if (bus.wishbone_err || bus.wishbone_ack) begin
          rsp_err_d = bus.wishbone_err;
          rsp_dat_d = (bus.wishbone_err || we_q) ? '0 : bus.wishbone_dat_r;
          bus_done  = 1'b1;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          rsp_timeout_d = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_dat_d     = '0;
          bus_done      = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
        if (bus_done) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = StIdle;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_count_q <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_w_q     <= '0;
      sel_q       <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_w_q     <= dat_w_d;
      sel_q       <= sel_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_dat        = rsp_dat_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.txn_count      = txn_count_q;
  assign bus.wishbone_adr   = adr_q;
  assign bus.wishbone_dat_w = dat_w_q;
  assign bus.wishbone_sel   = sel_q;
  assign bus.wishbone_cyc   = cyc_q;
  assign bus.wishbone_stb   = cyc_q;
  assign bus.wishbone_we    = we_q;
  assign bus.wishbone_cti   = 3'b000;
  assign bus.wishbone_bte   = 2'b00;
`ifdef WB_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone B4 classic-cycle bus master that turns single-word read/write commands into bus transactions against the DUT's `wishbone_*` slave port. It sits in the testbench wrapper between the simulation-side command source and the DUT, and drives the signals the host previously drove directly. It returns read data and completion status on a response channel. An optional bus-hang timeout aborts a cycle that is never acknowledged.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: number of cycles `stb` may stay high without `ack`/`err` before abort; legal range 1..65535.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  master can accept a command.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  30  word address.
- `cmd_dat`  in  32  write data.
- `cmd_sel`  in  4  byte selects.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_dat`  out  32  read data; 0 for writes, errors, and timeouts.
- `rsp_err`  out  1  slave returned `err`.
- `rsp_timeout`  out  1  cycle aborted by timeout.
- `txn_count`  out  16  completed-transaction counter.
- `wishbone_adr`  out  30; `wishbone_dat_w`  out  32; `wishbone_dat_r`  in  32; `wishbone_sel`  out  4.
- `wishbone_cyc`, `wishbone_stb`, `wishbone_we`  out  1 each.
- `wishbone_ack`, `wishbone_err`  in  1 each.
- `wishbone_cti`  out  3  constant 3'b000.
- `wishbone_bte`  out  2  constant 2'b00.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: `cmd_ready`=1. When `cmd_valid`&`cmd_ready` is sampled, register `adr`, `dat_w`, `sel`, and `we` onto the bus outputs, set `cyc`/`stb`=1, clear the timeout counter, and go to BUS.
- BUS: `cmd_ready`=0. Bus outputs are held stable.
  - On `err` (takes priority over a simultaneous `ack`): `rsp_err`=1, `rsp_dat`=0.
  - On `ack` alone: `rsp_dat`=`wishbone_dat_r` for a read, 0 for a write.
  - In either case, drop `cyc`/`stb`/`we`, set `rsp_valid`=1, and go to RESP.
  - Otherwise increment the timeout counter (see Configuration).
- RESP: `rsp_valid`=1 with `rsp_dat`/`rsp_err`/`rsp_timeout` held. When `rsp_ready` is sampled: clear `rsp_valid`, `rsp_err`, and `rsp_timeout`; increment `txn_count`; go to IDLE.
- `txn_count` counts every response handed off (ok, err, or timeout). It wraps 0xFFFF -> 0x0000.
- `cmd_*` is ignored outside IDLE. No pipelining: at most one outstanding transaction.
- `ack`/`err` arriving outside BUS are ignored.
- Reset mid-transaction: `cyc`/`stb` drop on the reset edge and the pending response is discarded.
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after; `rsp_valid`=0; `rsp_dat`=0; `rsp_err`=0; `rsp_timeout`=0; `txn_count`=0; `wishbone_cyc`/`stb`/`we`=0; `wishbone_adr`=0; `wishbone_dat_w`=0; `wishbone_sel`=0. State is IDLE.

## Timing
- Command handshake at edge N -> `cyc`/`stb` high from cycle N+1.
- `ack` sampled at edge M -> `cyc`/`stb` low and `rsp_valid` high from cycle M+1. Minimum bus occupancy is 1 cycle (zero-wait slave).
- `rsp_ready` sampled at edge R -> `cmd_ready` high from cycle R+1. Back-to-back transactions cost at least 3 cycles each.
- `rsp_ready` may be held high permanently. A response is then still presented for exactly 1 cycle.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined:
  - 16-bit counter active in BUS.
  - When it reaches `TIMEOUT_CYCLES` with no `ack`/`err` sampled: drop `cyc`/`stb`, set `rsp_timeout`=1, `rsp_err`=0, `rsp_dat`=0, and go to RESP.
  - `stb` is therefore high for exactly `TIMEOUT_CYCLES` cycles.
  - `ack`/`err` in the same cycle as expiry wins over the timeout.
- Undefined: no counter; BUS waits indefinitely; `rsp_timeout` is tied to 0.

## Test plan
- Write, adr=0x0000_0010, dat=0xDEADBEEF, sel=0xF, zero-wait slave -> one `stb` cycle with matching adr/dat/sel and we=1; `rsp_err`=0; `rsp_dat`=0; `txn_count`=1.
- Read, adr=0x0000_0020, slave acks after 3 wait cycles with 0xCAFEF00D -> `stb` high 4 cycles, we=0; `rsp_dat`=0xCAFEF00D; `cti`=0, `bte`=0 throughout.
- Slave asserts `ack` and `err` in the same cycle on a read -> `rsp_err`=1, `rsp_dat`=0.
- With `WB_MASTER_TIMEOUT_EN`, TIMEOUT_CYCLES=8, slave never responds -> `stb` high exactly 8 cycles, then `rsp_timeout`=1, bus idle; next command proceeds normally.
- `rsp_ready` held low 5 cycles after a read -> `rsp_valid`/`rsp_dat` stable for 5 cycles and `cmd_ready`=0; a `cmd_valid` pulse during this window produces no bus cycle.
- Reset asserted during BUS with the slave stalling -> `cyc`/`stb`=0 the next cycle, `rsp_valid`=0, `txn_count`=0, `cmd_ready`=1 one cycle after reset deasserts.
